// File: rtl/disp_hex_mux_n.sv
// disp_hex_mux_n: time-multiplexed common-anode 7-segment driver.
// Each digit gets one slot of 2^REFRESH_BITS cycles. Inputs are captured
// once per frame into shadow registers, so a frame never shows a mix of
// old and new values. Brightness is a 3-bit PWM on the slot phase, and
// phase 0 is always dark so the anode switch is never visible as ghosting.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
`timescale 1ns/1ps
module disp_hex_mux_n #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_BITS = 16,
    parameter int BLINK_BITS   = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [5*NUM_DIGITS-1:0] hex_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   en_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic [2:0]              bright,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [7:0]              sseg_out,
    output logic [2:0]              digit_idx,
    output logic                    frame_tick
);

    localparam int         IDX_W = $clog2(NUM_DIGITS);
    localparam logic [2:0] LAST  = 3'(NUM_DIGITS - 1);

    logic [REFRESH_BITS-1:0]          sc;
    logic [BLINK_BITS-1:0]            blink_cnt;
    logic [2:0]                       bright_s;
    logic [NUM_DIGITS-1:0][4:0]       hex_s;
    logic [NUM_DIGITS-1:0]            dp_s;
    logic [NUM_DIGITS-1:0]            en_s;
    logic [NUM_DIGITS-1:0]            blink_s;

    logic [5*NUM_DIGITS-1:0]          hex_ld;
    logic [NUM_DIGITS-1:0]            en_ld;

    logic [IDX_W-1:0]                 cur;
    logic [2:0]                       phase;
    logic                             slot_end;
    logic                             frame_end;
    logic                             lit;
    logic [4:0]                       cur_code;
    logic [6:0]                       glyph;
    logic [NUM_DIGITS-1:0]            an_sel;

    assign cur       = digit_idx[IDX_W-1:0];
    assign phase     = sc[REFRESH_BITS-1 -: 3];
    assign slot_end  = (sc == '1);
    assign frame_end = slot_end && (digit_idx == LAST);
    assign cur_code  = hex_s[cur];

`ifdef LEADING_ZERO_BLANK_EN
    logic run;

    // Leading-zero blanking on the captured values: walking down from the top
    // digit, enabled zero digits become a blank glyph; such a digit stays lit
    // only to show its decimal point. Digit 0 is never touched.
    always_comb begin
        hex_ld = hex_in;
        en_ld  = en_in;
        run    = 1'b1;
        for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (run && en_in[i] && (hex_in[5*i +: 5] == 5'h00)) begin
                hex_ld[5*i +: 5] = 5'h12;
                en_ld[i]         = dp_in[i];
            end else begin
                run = 1'b0;
            end
        end
    end
`else
    assign hex_ld = hex_in;
    assign en_ld  = en_in;
`endif

    // Slot counter, digit index and free-running blink counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sc        <= '0;
            digit_idx <= '0;
            blink_cnt <= '0;
        end else begin
            sc        <= sc + 1'b1;
            blink_cnt <= blink_cnt + 1'b1;
            if (slot_end) begin
                digit_idx <= (digit_idx == LAST) ? 3'd0 : digit_idx + 3'd1;
            end
        end
    end

    // Frame-coherent snapshot of digit inputs, brightness sampled per slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hex_s      <= '0;
            dp_s       <= '0;
            en_s       <= '0;
            blink_s    <= '0;
            bright_s   <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (slot_end) begin
                bright_s <= bright;
            end
            if (frame_end) begin
                hex_s   <= hex_ld;
                dp_s    <= dp_in;
                en_s    <= en_ld;
                blink_s <= blink_in;
            end
        end
    end

    // Lit decision: enabled, inside the PWM window, not in the blink-off half.
    always_comb begin
        lit = en_s[cur] && (phase != 3'd0) && (phase <= bright_s) &&
              !(blink_s[cur] && blink_cnt[BLINK_BITS-1]);
    end

    // Anode select for the current digit, active low.
    always_comb begin
        an_sel      = '1;
        an_sel[cur] = 1'b0;
    end

    // Glyph decode, segments a..g on bits 6..0, active low.
    always_comb begin
        case (cur_code)
            5'h00:   glyph = 7'b0000001;
            5'h01:   glyph = 7'b1001111;
            5'h02:   glyph = 7'b0010010;
            5'h03:   glyph = 7'b0000110;
            5'h04:   glyph = 7'b1001100;
            5'h05:   glyph = 7'b0100100;
            5'h06:   glyph = 7'b0100000;
            5'h07:   glyph = 7'b0001111;
            5'h08:   glyph = 7'b0000000;
            5'h09:   glyph = 7'b0000100;
            5'h0A:   glyph = 7'b0001000;
            5'h0B:   glyph = 7'b1100000;
            5'h0C:   glyph = 7'b0110001;
            5'h0D:   glyph = 7'b1000010;
            5'h0E:   glyph = 7'b0110000;
            5'h0F:   glyph = 7'b0111000;
            5'h10:   glyph = 7'b1000001;
            5'h11:   glyph = 7'b1111110;
            5'h12:   glyph = 7'b1111111;
            5'h13:   glyph = 7'b0001001;
            5'h14:   glyph = 7'b1100010;
            5'h15:   glyph = 7'b0011100;
            5'h16:   glyph = 7'b1111001;
            5'h17:   glyph = 7'b1001001;
            default: glyph = 7'b1111100;
        endcase
    end

    // Registered pin drivers, one cycle behind the slot state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_out   <= '1;
            sseg_out <= 8'hFF;
        end else if (lit) begin
            an_out   <= an_sel;
            sseg_out <= {~dp_s[cur], glyph};
        end else begin
            an_out   <= '1;
            sseg_out <= 8'hFF;
        end
    end

endmodule

// File: tb/tb_disp_hex_mux_n.sv
// Testbench for disp_hex_mux_n with NUM_DIGITS=4, REFRESH_BITS=4, BLINK_BITS=6.
// One slot = 16 cycles, one frame = 64 cycles, blink period = 64 cycles.
`timescale 1ns/1ps
module tb_disp_hex_mux_n;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] hex_in;
    logic [3:0]  dp_in, en_in, blink_in;
    logic [2:0]  bright;
    logic [3:0]  an_out;
    logic [7:0]  sseg_out;
    logic [2:0]  digit_idx;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [19:0]      hex;
        logic [3:0]       dp;
        logic [3:0]       en;
        logic [3:0]       blink;
        logic [2:0]       bright;
        logic [3:0][4:0]  lit;
        logic [3:0][7:0]  seg;
    } vec_t;

    vec_t vecs[10];
    vec_t all8;

    disp_hex_mux_n #(
        .NUM_DIGITS  (4),
        .REFRESH_BITS(4),
        .BLINK_BITS  (6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hex_in    (hex_in),
        .dp_in     (dp_in),
        .en_in     (en_in),
        .blink_in  (blink_in),
        .bright    (bright),
        .an_out    (an_out),
        .sseg_out  (sseg_out),
        .digit_idx (digit_idx),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [19:0] h, input logic [3:0] d, input logic [3:0] e,
                                input logic [3:0] b, input logic [2:0] br,
                                input int l3, input int l2, input int l1, input int l0,
                                input logic [31:0] s);
        vec_t v;
        v.hex    = h;
        v.dp     = d;
        v.en     = e;
        v.blink  = b;
        v.bright = br;
        v.lit    = {5'(l3), 5'(l2), 5'(l1), 5'(l0)};
        v.seg    = s;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        hex_in   = v.hex;
        dp_in    = v.dp;
        en_in    = v.en;
        blink_in = v.blink;
        bright   = v.bright;
    endtask

    // Lets the pending inputs be captured: 64 cycles, frame_tick only on the last.
    task automatic skip_frame(input string name);
        int bad = 0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            if (frame_tick !== (k == 64)) bad++;
        end
        chk(name, bad, 0);
    endtask

    // Observes one full frame of output starting right after a frame_tick.
    // Sample k reflects slot state k-1: digit (k-1)/16, sc (k-1)%16.
    task automatic measure(input string name, input vec_t v, input int chg_at,
                           input logic [19:0] chg_hex);
        int         lit[4];
        int         bad = 0;
        int         d;
        logic [3:0] exp_an;
        for (int i = 0; i < 4; i++) lit[i] = 0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            if (k == chg_at) hex_in = chg_hex;
            d      = (k - 1) / 16;
            exp_an = ~(4'b0001 << d);
            if (int'(digit_idx) != (k % 64) / 16) bad++;
            if (frame_tick !== (k == 64)) bad++;
            if (an_out == 4'hF) begin
                if (sseg_out != 8'hFF) bad++;
            end else if (an_out != exp_an) begin
                bad++;
            end else begin
                lit[d]++;
                if (sseg_out != v.seg[d]) bad++;
            end
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_lit%0d", name, i), lit[i], int'(v.lit[i]));
        chk({name, "_bad"}, bad, 0);
    endtask

    // Counts cycles from reset release to the first frame_tick; display must stay dark.
    task automatic first_tick(input string name);
        int k;
        int lit_cnt = 0;
        for (k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (an_out != 4'hF) lit_cnt++;
            if (frame_tick) break;
        end
        chk({name, "_cycles"}, k, 64);
        chk({name, "_dark"}, lit_cnt, 0);
    endtask

    initial begin
        // Table: hex digit3..0, dp, en, blink, bright, lit per digit 3..0, seg per digit 3..0.
        vecs[0] = mk({5'h00, 5'h01, 5'h02, 5'h03}, 4'b0000, 4'hF, 4'b0000, 3'd7,
                     LZB ? 0 : 14, 14, 14, 14, {8'h81, 8'hCF, 8'h92, 8'h86});
        vecs[1] = mk({5'h00, 5'h01, 5'h02, 5'h03}, 4'b0000, 4'hF, 4'b0000, 3'd3,
                     LZB ? 0 : 6, 6, 6, 6, {8'h81, 8'hCF, 8'h92, 8'h86});
        vecs[2] = mk({5'h00, 5'h01, 5'h02, 5'h03}, 4'b0000, 4'hF, 4'b0000, 3'd0,
                     0, 0, 0, 0, {8'h81, 8'hCF, 8'h92, 8'h86});
        // Blink MSB is high exactly during the slots of digits 2 and 3 (the
        // 64-cycle blink period lines up with the frame from reset), so
        // blinking digit 1 leaves it lit while blinking digit 2 darkens it.
        vecs[3] = mk({5'h00, 5'h01, 5'h02, 5'h03}, 4'b0000, 4'hF, 4'b0010, 3'd7,
                     LZB ? 0 : 14, 14, 14, 14, {8'h81, 8'hCF, 8'h92, 8'h86});
        vecs[4] = mk({5'h00, 5'h01, 5'h02, 5'h03}, 4'b0000, 4'hF, 4'b0100, 3'd7,
                     LZB ? 0 : 14, 0, 14, 14, {8'h81, 8'hCF, 8'h92, 8'h86});
        vecs[5] = mk({5'h1F, 5'h15, 5'h13, 5'h10}, 4'b0101, 4'hF, 4'b0000, 3'd5,
                     10, 10, 10, 10, {8'hFC, 8'h1C, 8'h89, 8'h41});
        vecs[6] = mk({5'h17, 5'h16, 5'h14, 5'h11}, 4'b0000, 4'b1011, 4'b0000, 3'd7,
                     14, 0, 14, 14, {8'hC9, 8'hF9, 8'hE2, 8'hFE});
        vecs[7] = mk({5'h0F, 5'h08, 5'h0B, 5'h0A}, 4'b1000, 4'hF, 4'b0000, 3'd1,
                     2, 2, 2, 2, {8'h38, 8'h80, 8'hE0, 8'h88});
        vecs[8] = mk({5'h00, 5'h00, 5'h05, 5'h00}, 4'b0000, 4'hF, 4'b0000, 3'd7,
                     LZB ? 0 : 14, LZB ? 0 : 14, 14, 14, {8'h81, 8'h81, 8'hA4, 8'h81});
        vecs[9] = mk({5'h00, 5'h00, 5'h05, 5'h00}, 4'b0100, 4'hF, 4'b0000, 3'd7,
                     LZB ? 0 : 14, 14, 14, 14,
                     {8'h81, LZB ? 8'h7F : 8'h01, 8'hA4, 8'h81});
        all8    = mk({5'h08, 5'h08, 5'h08, 5'h08}, 4'b0000, 4'hF, 4'b0000, 3'd7,
                     14, 14, 14, 14, {8'h80, 8'h80, 8'h80, 8'h80});

        reset = 1'b0;
        apply(vecs[0]);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an",   int'(an_out),     4'hF);
        chk("rst_sseg", int'(sseg_out),   8'hFF);
        chk("rst_tick", int'(frame_tick), 0);
        chk("rst_idx",  int'(digit_idx),  0);
        @(negedge clk);
        reset = 1'b1;
        first_tick("init");

        for (int i = 0; i < 10; i++) begin
            apply(vecs[i]);
            skip_frame($sformatf("v%0d_load", i));
            measure($sformatf("v%0d", i), vecs[i], 0, 20'h0);
        end

        // Mid-frame input change stays invisible until the next snapshot.
        apply(vecs[0]);
        skip_frame("mid_load");
        measure("mid_old", vecs[0], 20, all8.hex);
        measure("mid_new", all8, 0, 20'h0);

        // Asynchronous reset in the middle of a lit slot.
        repeat (30) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_an",   int'(an_out),     4'hF);
        chk("arst_sseg", int'(sseg_out),   8'hFF);
        chk("arst_tick", int'(frame_tick), 0);
        begin
            int bad = 0;
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                if (an_out != 4'hF || sseg_out != 8'hFF || digit_idx != 3'd0) bad++;
            end
            chk("arst_hold", bad, 0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("arst_idx", int'(digit_idx), 0);
        first_tick("restart");
        measure("resume", all8, 0, 20'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
